// File: rtl/com_pkg.sv
// Shared definitions for the com_* packet link: header bytes, receive FSM state encoding, error bit positions.
package com_pkg;

    localparam logic [7:0] HEAD0_DEF = 8'h55;
    localparam logic [7:0] HEAD1_DEF = 8'hAA;

    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_HEAD0 = 4'd1;
    localparam logic [3:0] ST_HEAD1 = 4'd2;
    localparam logic [3:0] ST_BTYPE = 4'd3;
    localparam logic [3:0] ST_LENH  = 4'd4;
    localparam logic [3:0] ST_LENL  = 4'd5;
    localparam logic [3:0] ST_DATA  = 4'd6;
    localparam logic [3:0] ST_CSUM  = 4'd7;
    localparam logic [3:0] ST_DONE  = 4'd8;

    localparam int ERR_SUM = 0;
    localparam int ERR_LEN = 1;
    localparam int ERR_TMO = 2;

endpackage

// File: rtl/com_pkt_tmo.sv
// Inter-byte timeout counter: counts enabled idle cycles, saturates at TMO, clears on demand.
module com_pkt_tmo
    import com_pkg::*;
#(
    parameter logic [15:0] TMO = 16'd50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [15:0] cnt;

    // NOTE: reset is tested inside the clocked block, so it is synchronous; state uses <= only.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && cnt != TMO) begin
            cnt <= cnt + 16'd1;
        end
    end

    assign expire = (cnt == TMO);

endmodule

// File: rtl/com_pkt_rx.sv
// Receive framer: hunts the two-byte header, checks type/length/checksum and writes payload bytes to RAM.
module com_pkt_rx
    import com_pkg::*;
#(
    parameter logic [7:0]  HEAD0    = HEAD0_DEF,
    parameter logic [7:0]  HEAD1    = HEAD1_DEF,
    parameter logic [11:0] MAX_DLEN = 12'd2048,
    parameter logic [15:0] TMO      = 16'd50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fs,
    output logic        fd,
    input  logic [11:0] ram_addr_init,
    input  logic [7:0]  com_rxd,
    input  logic        rx_vld,
    output logic [3:0]  btype,
    output logic [11:0] dlen,
    output logic [2:0]  err,
    output logic [11:0] ram_txa,
    output logic [7:0]  ram_txd,
    output logic        ram_txe
);

    logic [3:0]  state;
    logic [11:0] base;
    logic [11:0] idx;
    logic [7:0]  sum;
    logic [3:0]  lenh;
    logic [3:0]  btype_q;
    logic        in_frame;
    logic        tmo_expire;
    logic [11:0] dlen_n;

    assign in_frame = (state == ST_BTYPE) || (state == ST_LENH) || (state == ST_LENL) ||
                      (state == ST_DATA)  || (state == ST_CSUM);
    assign dlen_n   = {lenh, com_rxd};
    assign fd       = (state == ST_DONE);

    com_pkt_tmo #(.TMO(TMO)) u_tmo (
        .clk    (clk),
        .rst    (rst),
        .clr    (rx_vld || !in_frame),
        .en     (in_frame),
        .expire (tmo_expire)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            base    <= '0;
            idx     <= '0;
            sum     <= '0;
            lenh    <= '0;
            btype_q <= '0;
            btype   <= '0;
            dlen    <= '0;
            err     <= '0;
            ram_txa <= '0;
            ram_txd <= '0;
            ram_txe <= 1'b0;
        end else begin
            ram_txe <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (fs) begin
                        state <= ST_HEAD0;
                        base  <= ram_addr_init;
                        err   <= '0;
                    end
                end
                ST_DONE: begin
                    if (!fs) state <= ST_IDLE;
                end
                default: begin
                    // Abort wins over everything, then timeout, then byte handling.
                    if (!fs) begin
                        state <= ST_IDLE;
                    end else if (in_frame && tmo_expire) begin
                        err[ERR_TMO] <= 1'b1;
                        state        <= ST_DONE;
                    end else if (rx_vld) begin
                        case (state)
                            ST_HEAD0: begin
                                if (com_rxd == HEAD0) state <= ST_HEAD1;
                            end
                            ST_HEAD1: begin
                                if (com_rxd == HEAD1)      state <= ST_BTYPE;
                                else if (com_rxd == HEAD0) state <= ST_HEAD1;
                                else                       state <= ST_HEAD0;
                            end
                            ST_BTYPE: begin
                                if (com_rxd[7:4] != 4'd0) begin
                                    state <= ST_HEAD0;
                                end else begin
                                    btype_q <= com_rxd[3:0];
                                    sum     <= com_rxd;
                                    state   <= ST_LENH;
                                end
                            end
                            ST_LENH: begin
                                if (com_rxd[7:4] != 4'd0) begin
                                    state <= ST_HEAD0;
                                end else begin
                                    lenh  <= com_rxd[3:0];
                                    sum   <= sum + com_rxd;
                                    state <= ST_LENL;
                                end
                            end
                            ST_LENL: begin
                                sum   <= sum + com_rxd;
                                dlen  <= dlen_n;
                                btype <= btype_q;
                                if (dlen_n > MAX_DLEN) begin
                                    err[ERR_LEN] <= 1'b1;
                                    state        <= ST_DONE;
                                end else if (dlen_n == 12'd0) begin
                                    state <= ST_CSUM;
                                end else begin
                                    idx   <= '0;
                                    state <= ST_DATA;
                                end
                            end
                            ST_DATA: begin
                                sum     <= sum + com_rxd;
                                ram_txe <= 1'b1;
                                ram_txd <= com_rxd;
                                ram_txa <= base + idx;
                                idx     <= idx + 12'd1;
                                if (idx == dlen - 12'd1) state <= ST_CSUM;
                            end
                            ST_CSUM: begin
                                err[ERR_SUM] <= (com_rxd != sum);
                                state        <= ST_DONE;
                            end
                            default: state <= ST_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_com_pkt_rx.sv
// Directed bench for com_pkt_rx: expected RAM writes are queued as frames are built and checked as they appear.
module tb_com_pkt_rx;

    localparam logic [15:0] TMO_TB = 16'd40;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fs = 1'b0;
    logic        fd;
    logic [11:0] ram_addr_init = '0;
    logic [7:0]  com_rxd = '0;
    logic        rx_vld = 1'b0;
    logic [3:0]  btype;
    logic [11:0] dlen;
    logic [2:0]  err;
    logic [11:0] ram_txa;
    logic [7:0]  ram_txd;
    logic        ram_txe;

    typedef struct packed {
        logic [11:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t        sb[$];
    logic [7:0] fbytes[$];
    logic [7:0] payload[$];
    int         n_cmp = 0;
    int         n_mis = 0;

    com_pkt_rx #(.TMO(TMO_TB)) dut (
        .clk           (clk),
        .rst           (rst),
        .fs            (fs),
        .fd            (fd),
        .ram_addr_init (ram_addr_init),
        .com_rxd       (com_rxd),
        .rx_vld        (rx_vld),
        .btype         (btype),
        .dlen          (dlen),
        .err           (err),
        .ram_txa       (ram_txa),
        .ram_txd       (ram_txd),
        .ram_txe       (ram_txe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every write pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (ram_txe === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_write", {ram_txa, ram_txd}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("wr_addr", ram_txa, e.a);
                check("wr_data", ram_txd, e.d);
            end
        end
    end

    // Builds a full frame into fbytes and queues the payload writes it should cause.
    task automatic make_frame(input logic [3:0] bt, input logic [7:0] pl[$], input logic [11:0] base,
                              input logic bad_sum);
        logic [11:0] n;
        logic [7:0]  s;
        n = 12'(pl.size());
        s = {4'd0, bt} + {4'd0, n[11:8]} + n[7:0];
        fbytes = '{8'h55, 8'hAA, {4'd0, bt}, {4'd0, n[11:8]}, n[7:0]};
        for (int i = 0; i < pl.size(); i++) begin
            s = s + pl[i];
            fbytes.push_back(pl[i]);
            sb.push_back('{a: base + 12'(i), d: pl[i]});
        end
        fbytes.push_back(bad_sum ? s + 8'd1 : s);
    endtask

    task automatic send_bytes();
        for (int i = 0; i < fbytes.size(); i++) begin
            @(negedge clk);
            rx_vld  = 1'b1;
            com_rxd = fbytes[i];
        end
        @(negedge clk);
        rx_vld = 1'b0;
    endtask

    task automatic start(input logic [11:0] base);
        @(negedge clk);
        ram_addr_init = base;
        fs = 1'b1;
    endtask

    task automatic wait_fd(input int budget);
        for (int i = 0; i < budget && fd !== 1'b1; i++) @(negedge clk);
        check("fd_rise", fd, 1'b1);
    endtask

    task automatic finish_frame(input string tag, input logic [2:0] e_err, input logic [3:0] e_bt,
                                input logic [11:0] e_len);
        check({tag, "_err"}, err, e_err);
        check({tag, "_btype"}, btype, e_bt);
        check({tag, "_dlen"}, dlen, e_len);
        fs = 1'b0;
        @(negedge clk);
        check({tag, "_fd_fall"}, fd, 1'b0);
        check({tag, "_writes_left"}, sb.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_fd"}, fd, 1'b0);
        check({tag, "_err"}, err, 3'd0);
        check({tag, "_btype"}, btype, 4'd0);
        check({tag, "_dlen"}, dlen, 12'd0);
        check({tag, "_txa"}, ram_txa, 12'd0);
        check({tag, "_txd"}, ram_txd, 8'd0);
        check({tag, "_txe"}, ram_txe, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;

        // Good frame, payload 11 22 33 44 at 0x100.
        start(12'h100);
        payload = '{8'h11, 8'h22, 8'h33, 8'h44};
        make_frame(4'h3, payload, 12'h100, 1'b0);
        send_bytes();
        wait_fd(10);
        finish_frame("good", 3'b000, 4'h3, 12'd4);

        // Same frame with a corrupted checksum: payload still written.
        start(12'h100);
        make_frame(4'h3, payload, 12'h100, 1'b1);
        send_bytes();
        wait_fd(10);
        finish_frame("badsum", 3'b001, 4'h3, 12'd4);

        // Garbage then doubled header byte, zero-length frame.
        start(12'h200);
        fbytes = '{8'h12, 8'h55, 8'h55, 8'hAA, 8'h01, 8'h00, 8'h00, 8'h01};
        send_bytes();
        wait_fd(10);
        finish_frame("resync", 3'b000, 4'h1, 12'd0);

        // Address wrap at the top of RAM.
        start(12'hFFE);
        payload = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        make_frame(4'h5, payload, 12'hFFE, 1'b0);
        send_bytes();
        wait_fd(10);
        finish_frame("wrap", 3'b000, 4'h5, 12'd4);

        // Oversize length: no payload accepted.
        start(12'h000);
        fbytes = '{8'h55, 8'hAA, 8'h01, 8'h08, 8'h01};
        send_bytes();
        wait_fd(10);
        finish_frame("len", 3'b010, 4'h1, 12'h801);

        // Length 5 but only 2 payload bytes arrive, then silence.
        start(12'h300);
        fbytes = '{8'h55, 8'hAA, 8'h02, 8'h00, 8'h05, 8'h31, 8'h32};
        sb.push_back('{a: 12'h300, d: 8'h31});
        sb.push_back('{a: 12'h301, d: 8'h32});
        send_bytes();
        repeat (int'(TMO_TB) - 2) @(negedge clk);
        check("tmo_early", fd, 1'b0);
        wait_fd(20);
        finish_frame("tmo", 3'b100, 4'h2, 12'd5);

        // fs dropped mid-payload: the second write completes, nothing after.
        start(12'h400);
        fbytes = '{8'h55, 8'hAA, 8'h01, 8'h00, 8'h04, 8'h61, 8'h62};
        sb.push_back('{a: 12'h400, d: 8'h61});
        sb.push_back('{a: 12'h401, d: 8'h62});
        for (int i = 0; i < fbytes.size(); i++) begin
            @(negedge clk);
            rx_vld  = 1'b1;
            com_rxd = fbytes[i];
        end
        @(negedge clk);
        fs      = 1'b0;
        com_rxd = 8'h63;
        @(negedge clk);
        com_rxd = 8'h64;
        @(negedge clk);
        rx_vld = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_fd", fd, 1'b0);
        check("abort_writes_left", sb.size(), 0);

        // Reset mid-payload: outputs return to reset values.
        start(12'h500);
        fbytes = '{8'h55, 8'hAA, 8'h07, 8'h00, 8'h04, 8'h71};
        sb.push_back('{a: 12'h500, d: 8'h71});
        for (int i = 0; i < fbytes.size(); i++) begin
            @(negedge clk);
            rx_vld  = 1'b1;
            com_rxd = fbytes[i];
        end
        @(negedge clk);
        com_rxd = 8'h72;
        rst     = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        rx_vld = 1'b0;
        fs     = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_writes_left", sb.size(), 0);
        check("midrst_fd_idle", fd, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
